contador_descendente_recarga: RTL and testbench



---
 rtl/pong_pkg.sv | 15 +
 rtl/dec_cnt_core.sv | 45 ++++
 rtl/contador_descendente_recarga.sv | 89 ++++++++
 tb/tb_contador_descendente_recarga.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and defaults for the Pong timing blocks.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  // Default frame-tick timer geometry: serve delay of 10 frame strobes.
  localparam int DEFAULT_CNT_SIZE = 4;
  localparam int DEFAULT_RELOAD   = 9;

endpackage

// File: rtl/dec_cnt_core.sv
// Down-counter datapath: load with clamp to the terminal value, reload, guarded decrement.
module dec_cnt_core #(
  parameter int CNT_SIZE = 4,
  parameter int MIN_CNT  = 0,
  parameter int INIT_VAL = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [CNT_SIZE-1:0] load_val,
  input  logic                reload,
  input  logic [CNT_SIZE-1:0] reload_val,
  input  logic                dec,
  output logic [CNT_SIZE-1:0] cnt,
  output logic                zero_hit,
  output logic [CNT_SIZE-1:0] load_clamped
);

  localparam logic [CNT_SIZE-1:0] MIN_V  = CNT_SIZE'(MIN_CNT);
  localparam logic [CNT_SIZE-1:0] INIT_V = CNT_SIZE'(INIT_VAL);

  // With a zero floor nothing can sit below it, so skip the compare entirely.
  generate
    if (MIN_CNT == 0) begin : g_no_clamp
      assign load_clamped = load_val;
    end else begin : g_clamp
      assign load_clamped = (load_val < MIN_V) ? MIN_V : load_val;
    end
  endgenerate

  assign zero_hit = (cnt == MIN_V);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= INIT_V;
    end else if (load) begin
      cnt <= load_clamped;
    end else if (reload) begin
      cnt <= reload_val;
    end else if (dec && !zero_hit) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/contador_descendente_recarga.sv
// Loadable down-counting timer with one-shot/auto-reload modes and a terminal-count pulse.
//
// state      | meaning
// ST_IDLE    | loaded or reset, counter holds, waiting for start
// ST_RUN     | counter decrements on each en tick
// ST_PAUSED  | counter frozen until start resumes
// ST_EXPIRED | one-shot finished, cnt parked at MIN_CNT
module contador_descendente_recarga
  import pong_pkg::*;
#(
  parameter int CNT_SIZE       = DEFAULT_CNT_SIZE,
  parameter int MIN_CNT        = 0,
  parameter int RELOAD_DEFAULT = DEFAULT_RELOAD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [CNT_SIZE-1:0] load_val,
  input  logic                start,
  input  logic                pause,
  input  logic                auto_reload,
  input  logic                en,
  output logic [CNT_SIZE-1:0] cnt,
  output logic                zero_hit,
  output logic                done,
  output logic                busy
);

  localparam logic [CNT_SIZE-1:0] RELOAD_INIT = CNT_SIZE'(RELOAD_DEFAULT);

  state_t              state, state_nxt;
  logic [CNT_SIZE-1:0] reload_reg;
  logic [CNT_SIZE-1:0] load_clamped;
  logic                run_tick, term_tick, dec_go, reload_go, busy_nxt;

  dec_cnt_core #(
    .CNT_SIZE (CNT_SIZE),
    .MIN_CNT  (MIN_CNT),
    .INIT_VAL (RELOAD_DEFAULT)
  ) u_core (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .load_val     (load_val),
    .reload       (reload_go),
    .reload_val   (reload_reg),
    .dec          (dec_go),
    .cnt          (cnt),
    .zero_hit     (zero_hit),
    .load_clamped (load_clamped)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      reload_reg <= RELOAD_INIT;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) reload_reg <= load_clamped;
      done  <= term_tick;
      busy  <= busy_nxt;
    end
  end

  // A start that has nothing to do (already running) lets pause/en through.
  always_comb begin
    state_nxt = state;
    if (load) begin
      state_nxt = ST_IDLE;
    end else if (start && state != ST_RUN) begin
      state_nxt = ST_RUN;
    end else if (pause && state == ST_RUN) begin
      state_nxt = ST_PAUSED;
    end else if (en && state == ST_RUN && zero_hit && !auto_reload) begin
      state_nxt = ST_EXPIRED;
    end
  end

  always_comb begin
    run_tick  = !load && !pause && en && (state == ST_RUN);
    term_tick = run_tick && zero_hit;
    dec_go    = run_tick && !zero_hit;
    reload_go = !load && ((start && state == ST_EXPIRED) || (term_tick && auto_reload));
    busy_nxt  = (state_nxt == ST_RUN) || (state_nxt == ST_PAUSED);
  end

endmodule

// File: tb/tb_contador_descendente_recarga.sv
// Randomized + directed bench for the down-counting timer, default and MIN_CNT=2 builds.
module tb_contador_descendente_recarga;

  logic       clk = 1'b0;
  logic       rst, load, start, pause, auto_reload, en;
  logic [3:0] load_val;
  logic [3:0] cnt_a, cnt_b;
  logic       zh_a, zh_b, done_a, done_b, busy_a, busy_b;

  int checks   = 0;
  int failures = 0;

  // Reference model: index 0 = MIN_CNT 0 build, index 1 = MIN_CNT 2 build.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXPIRED = 3;
  int mins [2] = '{0, 2};
  int m_cnt[2], m_rel[2], m_mode[2], m_done[2];

  always #5 clk = ~clk;

  contador_descendente_recarga dut_a (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .auto_reload(auto_reload), .en(en),
    .cnt(cnt_a), .zero_hit(zh_a), .done(done_a), .busy(busy_a)
  );

  contador_descendente_recarga #(.MIN_CNT(2)) dut_b (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .auto_reload(auto_reload), .en(en),
    .cnt(cnt_b), .zero_hit(zh_b), .done(done_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_step();
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 0;
      if (rst) begin
        m_cnt[k] = 9; m_rel[k] = 9; m_mode[k] = M_IDLE;
      end else if (load) begin
        m_rel[k]  = (int'(load_val) < mins[k]) ? mins[k] : int'(load_val);
        m_cnt[k]  = m_rel[k];
        m_mode[k] = M_IDLE;
      end else if (start && m_mode[k] != M_RUN) begin
        if (m_mode[k] == M_EXPIRED) m_cnt[k] = m_rel[k];
        m_mode[k] = M_RUN;
      end else if (pause && m_mode[k] == M_RUN) begin
        m_mode[k] = M_PAUSED;
      end else if (en && m_mode[k] == M_RUN) begin
        if (m_cnt[k] == mins[k]) begin
          m_done[k] = 1;
          if (auto_reload) m_cnt[k] = m_rel[k];
          else m_mode[k] = M_EXPIRED;
        end else begin
          m_cnt[k] = m_cnt[k] - 1;
        end
      end
    end
  endfunction

  function automatic int m_busy(input int k);
    return (m_mode[k] == M_RUN || m_mode[k] == M_PAUSED) ? 1 : 0;
  endfunction

  task automatic check_all();
    chk("cnt_a",  int'(cnt_a),  m_cnt[0]);
    chk("zh_a",   int'(zh_a),   (m_cnt[0] == mins[0]) ? 1 : 0);
    chk("done_a", int'(done_a), m_done[0]);
    chk("busy_a", int'(busy_a), m_busy(0));
    chk("cnt_b",  int'(cnt_b),  m_cnt[1]);
    chk("zh_b",   int'(zh_b),   (m_cnt[1] == mins[1]) ? 1 : 0);
    chk("done_b", int'(done_b), m_done[1]);
    chk("busy_b", int'(busy_b), m_busy(1));
  endtask

  task automatic tick(input logic r, input logic l, input logic [3:0] lv,
                      input logic s, input logic p, input logic ar, input logic e);
    rst = r; load = l; load_val = lv; start = s; pause = p; auto_reload = ar; en = e;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; load_val = '0; start = 1'b0;
    pause = 1'b0; auto_reload = 1'b0; en = 1'b0;

    // Reset state and the default 10-tick one-shot.
    tick(1, 0, 0, 0, 0, 0, 0);
    chk("rst_cnt", int'(cnt_a), 9);
    chk("rst_busy", int'(busy_a), 0);
    tick(0, 0, 0, 1, 0, 0, 0);
    chk("start_busy", int'(busy_a), 1);
    for (int i = 1; i <= 10; i++) begin
      tick(0, 0, 0, 0, 0, 0, 1);
      if (i < 10) chk("os_cnt", int'(cnt_a), 9 - i);
      if (i < 10) chk("os_nodone", int'(done_a), 0);
    end
    chk("os_done", int'(done_a), 1);
    chk("os_busy", int'(busy_a), 0);
    tick(0, 0, 0, 0, 0, 0, 1);
    chk("os_done_once", int'(done_a), 0);
    chk("os_hold0", int'(cnt_a), 0);

    // Auto-reload from 3, en held high for 12 ticks.
    tick(0, 1, 3, 0, 0, 1, 0);
    tick(0, 0, 0, 1, 0, 1, 0);
    for (int i = 1; i <= 12; i++) begin
      tick(0, 0, 0, 0, 0, 1, 1);
      chk("ar_done", int'(done_a), (i % 4 == 0) ? 1 : 0);
      chk("ar_cnt", int'(cnt_a), (i % 4 == 0) ? 3 : 3 - (i % 4));
    end

    // Pause/resume from 9.
    tick(0, 1, 9, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 0, 0, 1);
    chk("pz_cnt5", int'(cnt_a), 5);
    tick(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 0, 0, 0, 1);
    chk("pz_hold", int'(cnt_a), 5);
    chk("pz_busy", int'(busy_a), 1);
    tick(0, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 0, 0, 0, 1);
    chk("pz_zero", int'(cnt_a), 0);
    tick(0, 0, 0, 0, 0, 0, 1);
    chk("pz_done", int'(done_a), 1);

    // Load and start together: load wins.
    tick(0, 1, 7, 1, 0, 0, 0);
    chk("ls_cnt", int'(cnt_a), 7);
    chk("ls_idle", int'(busy_a), 0);
    tick(0, 0, 0, 1, 0, 0, 0);
    chk("ls_run", int'(busy_a), 1);

    // Clamp on the MIN_CNT=2 build.
    tick(0, 1, 1, 0, 0, 0, 0);
    chk("clamp_cnt", int'(cnt_b), 2);
    tick(0, 0, 0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 1);
    chk("clamp_done", int'(done_b), 1);

    // Reset mid-run at cnt=4 alongside en.
    tick(0, 1, 9, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 0, 0, 0, 1);
    chk("mr_cnt4", int'(cnt_a), 4);
    tick(1, 0, 0, 0, 0, 0, 1);
    chk("mr_cnt", int'(cnt_a), 9);
    chk("mr_done", int'(done_a), 0);
    chk("mr_busy", int'(busy_a), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 4,
           4'($urandom_range(0, 15)), $urandom_range(0, 99) < 12,
           $urandom_range(0, 99) < 8, (i / 256) % 2 == 1,
           $urandom_range(0, 99) < 60);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
